// File: rtl/rst_sequencer.sv
// rst_sequencer: ordered reset release for the image pipe.
// Synchronizes the board reset and the register-CPU soft reset request,
// then releases the register block first and the pixel pipeline second.
// Optional build macro RST_SEQ_CAUSE_EN adds the soft_rst_cnt and
// last_cause outputs, which are cleared only by s_rst_n.
`timescale 1ns/1ps

module rst_sequencer #(
  parameter int SYNC_STAGES      = 2,
  parameter int REG_RELEASE_DLY  = 4,
  parameter int PIPE_RELEASE_DLY = 16,
  parameter int SOFT_MIN_PULSE   = 8,
  parameter int CNT_W            = 8
) (
  input  logic clk,
  input  logic s_rst_n,
  input  logic reg_cpu_rst_n,
  output logic rst_sync_n,
  output logic reg_rst_n,
  output logic pipe_rst_n,
  output logic rst_done,
  output logic soft_rst_active
`ifdef RST_SEQ_CAUSE_EN
  ,
  output logic [CNT_W-1:0] soft_rst_cnt,
  output logic [0:0]       last_cause
`endif
);

  // Out-of-range parameters are rejected while elaborating.
  if (SYNC_STAGES < 2 || REG_RELEASE_DLY < 1 || PIPE_RELEASE_DLY < 1 ||
      SOFT_MIN_PULSE < 1) begin : g_range_err
    $error("rst_sequencer: parameter below its legal minimum");
  end
  if (REG_RELEASE_DLY >= (1 << CNT_W) || PIPE_RELEASE_DLY >= (1 << CNT_W) ||
      SOFT_MIN_PULSE >= (1 << CNT_W)) begin : g_width_err
    $error("rst_sequencer: a delay does not fit in CNT_W bits");
  end

  // Counter values on which the matching edge fires: the counter is cleared
  // on the edge that starts a phase, so the phase ends at count DLY-1.
  localparam logic [CNT_W-1:0] C_REG_LAST  = CNT_W'(REG_RELEASE_DLY - 1);
  localparam logic [CNT_W-1:0] C_PIPE_LAST = CNT_W'(PIPE_RELEASE_DLY - 1);
  localparam logic [CNT_W-1:0] C_SOFT_LAST = CNT_W'(SOFT_MIN_PULSE - 1);
  localparam logic [CNT_W-1:0] C_SOFT_MAX  = CNT_W'(SOFT_MIN_PULSE);

  typedef enum logic [2:0] {
    ST_HARD_RST  = 3'd0,
    ST_REG_WAIT  = 3'd1,
    ST_PIPE_WAIT = 3'd2,
    ST_RUN       = 3'd3,
    ST_SOFT_RST  = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_rst_chain;
  logic [SYNC_STAGES-1:0] r_soft_chain;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_reg_rst_n, w_reg_rst_n_nxt;
  logic                   r_pipe_rst_n, w_pipe_rst_n_nxt;
  logic                   r_rst_done, w_rst_done_nxt;
  logic                   r_soft_active, w_soft_active_nxt;
  logic                   w_sync_next;
  logic                   w_soft_req_n;

  // Hard reset synchronizer: asynchronous assert, deassert after SYNC_STAGES edges.
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) r_rst_chain <= '0;
    else          r_rst_chain <= {r_rst_chain[SYNC_STAGES-2:0], 1'b1};
  end

  // Soft request synchronizer; idles at 1 (no request).
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) r_soft_chain <= '1;
    else          r_soft_chain <= {r_soft_chain[SYNC_STAGES-2:0], reg_cpu_rst_n};
  end

  // rst_sync_n will be 1 after this edge, so the FSM leaves HARD_RST on
  // the same edge (T0).
  assign w_sync_next  = r_rst_chain[SYNC_STAGES-2];
  assign w_soft_req_n = r_soft_chain[SYNC_STAGES-1];

  // FSM, delay counter and output flops.
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state       <= ST_HARD_RST;
      r_cnt         <= '0;
      r_reg_rst_n   <= 1'b0;
      r_pipe_rst_n  <= 1'b0;
      r_rst_done    <= 1'b0;
      r_soft_active <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_reg_rst_n   <= w_reg_rst_n_nxt;
      r_pipe_rst_n  <= w_pipe_rst_n_nxt;
      r_rst_done    <= w_rst_done_nxt;
      r_soft_active <= w_soft_active_nxt;
    end
  end

  // Next state and next output values; a soft request outranks any release.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_reg_rst_n_nxt   = r_reg_rst_n;
    w_pipe_rst_n_nxt  = r_pipe_rst_n;
    w_rst_done_nxt    = r_rst_done;
    w_soft_active_nxt = r_soft_active;
    case (r_state)
      ST_HARD_RST: begin
        if (w_sync_next) begin
          w_state_nxt = ST_REG_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_REG_WAIT, ST_PIPE_WAIT, ST_RUN: begin
        if (!w_soft_req_n) begin
          w_state_nxt       = ST_SOFT_RST;
          w_cnt_nxt         = '0;
          w_reg_rst_n_nxt   = 1'b0;
          w_pipe_rst_n_nxt  = 1'b0;
          w_rst_done_nxt    = 1'b0;
          w_soft_active_nxt = 1'b1;
        end else if (r_state == ST_REG_WAIT) begin
          if (r_cnt == C_REG_LAST) begin
            w_state_nxt     = ST_PIPE_WAIT;
            w_cnt_nxt       = '0;
            w_reg_rst_n_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else if (r_state == ST_PIPE_WAIT) begin
          if (r_cnt == C_PIPE_LAST) begin
            w_state_nxt      = ST_RUN;
            w_cnt_nxt        = '0;
            w_pipe_rst_n_nxt = 1'b1;
            w_rst_done_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_SOFT_RST: begin
        // Leave on the edge where the pulse reaches its minimum length,
        // provided the request has been withdrawn.
        if (r_cnt >= C_SOFT_LAST && w_soft_req_n) begin
          w_state_nxt       = ST_REG_WAIT;
          w_cnt_nxt         = '0;
          w_soft_active_nxt = 1'b0;
        end else if (r_cnt < C_SOFT_MAX) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_HARD_RST;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign rst_sync_n      = r_rst_chain[SYNC_STAGES-1];
  assign reg_rst_n       = r_reg_rst_n;
  assign pipe_rst_n      = r_pipe_rst_n;
  assign rst_done        = r_rst_done;
  assign soft_rst_active = r_soft_active;

`ifdef RST_SEQ_CAUSE_EN
  logic             w_soft_entry;
  logic [CNT_W-1:0] r_soft_rst_cnt;
  logic             r_last_cause;

  assign w_soft_entry = (r_state != ST_SOFT_RST) && (w_state_nxt == ST_SOFT_RST);

  // Soft-reset history, survives soft resets and clears only on s_rst_n.
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_soft_rst_cnt <= '0;
      r_last_cause   <= 1'b0;
    end else if (w_soft_entry) begin
      if (r_soft_rst_cnt != '1) r_soft_rst_cnt <= r_soft_rst_cnt + 1'b1;
      r_last_cause <= 1'b1;
    end
  end

  assign soft_rst_cnt = r_soft_rst_cnt;
  assign last_cause   = r_last_cause;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed steps plus randomized soft/hard reset traffic,
// checked every cycle against a timestamp-based model of the release rules.
`timescale 1ns/1ps

module tb_rst_sequencer;

  localparam int SYNC    = 2;
  localparam int REG     = 4;
  localparam int PIPE    = 16;
  localparam int MIN     = 8;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int M_HARD  = 0;
  localparam int M_SEQ   = 1;
  localparam int M_SOFT  = 2;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic s_rst_n;
  logic reg_cpu_rst_n;
  logic rst_sync_n, reg_rst_n, pipe_rst_n, rst_done, soft_rst_active;
`ifdef RST_SEQ_CAUSE_EN
  logic [CNT_W-1:0] soft_rst_cnt;
  logic [0:0]       last_cause;
`endif

  always #5 clk = ~clk;

  rst_sequencer #(
    .SYNC_STAGES(SYNC), .REG_RELEASE_DLY(REG), .PIPE_RELEASE_DLY(PIPE),
    .SOFT_MIN_PULSE(MIN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .s_rst_n(s_rst_n),
    .reg_cpu_rst_n(reg_cpu_rst_n),
    .rst_sync_n(rst_sync_n),
    .reg_rst_n(reg_rst_n),
    .pipe_rst_n(pipe_rst_n),
    .rst_done(rst_done),
    .soft_rst_active(soft_rst_active)
`ifdef RST_SEQ_CAUSE_EN
    ,
    .soft_rst_cnt(soft_rst_cnt),
    .last_cause(last_cause)
`endif
  );

  // ---------------- reference model ----------------
  // Time is counted in clock edges. The model remembers when the current
  // release sequence started (t0) or when the soft reset began (ts) and
  // derives every output from the distance to that edge.
  int   vectors = 0;
  int   miscompares = 0;
  int   edge_n = 0;
  int   rel = 0;
  int   mode = M_HARD;
  int   t0 = 0;
  int   ts = 0;
  int   m_cnt = 0;
  logic m_cause = 1'b0;
  logic req_q[$];
  logic prev_reg = 1'b0;
  logic prev_pipe = 1'b0;

  function automatic void model_hard();
    rel  = 0;
    mode = M_HARD;
    req_q.delete();
    for (int i = 0; i < SYNC; i++) req_q.push_back(1'b1);
    m_cnt   = 0;
    m_cause = 1'b0;
  endfunction

  // Called once per rising edge with the inputs that edge sampled.
  function automatic void model_edge();
    logic seen;
    edge_n++;
    if (!s_rst_n) return;
    seen = req_q.pop_front();          // request as sampled SYNC edges ago
    req_q.push_back(reg_cpu_rst_n);
    if (rel < 100000) rel++;
    case (mode)
      M_HARD: if (rel == SYNC) begin mode = M_SEQ; t0 = edge_n; end
      M_SEQ: if (!seen) begin
        mode = M_SOFT;
        ts   = edge_n;
        if (m_cnt < CNT_MAX) m_cnt++;
        m_cause = 1'b1;
      end
      M_SOFT: if ((edge_n - ts) >= MIN && seen) begin mode = M_SEQ; t0 = edge_n; end
      default: mode = M_HARD;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic e_seq_reg, e_seq_pipe;
    e_seq_reg  = (mode == M_SEQ) && ((edge_n - t0) >= REG);
    e_seq_pipe = (mode == M_SEQ) && ((edge_n - t0) >= REG + PIPE);
    chk({tag, ".rst_sync_n"},      32'(rst_sync_n),      32'(rel >= SYNC));
    chk({tag, ".reg_rst_n"},       32'(reg_rst_n),       32'(e_seq_reg));
    chk({tag, ".pipe_rst_n"},      32'(pipe_rst_n),      32'(e_seq_pipe));
    chk({tag, ".rst_done"},        32'(rst_done),        32'(e_seq_pipe));
    chk({tag, ".soft_rst_active"}, 32'(soft_rst_active), 32'(mode == M_SOFT));
`ifdef RST_SEQ_CAUSE_EN
    chk({tag, ".soft_rst_cnt"},    32'(soft_rst_cnt),    32'(m_cnt));
    chk({tag, ".last_cause"},      32'(last_cause),      32'(m_cause));
`endif
    // Release ordering: register block strictly before pipeline.
    chk({tag, ".order_reg_rise"},  32'(reg_rst_n && !prev_reg && pipe_rst_n), 32'd0);
    chk({tag, ".order_pipe_rise"}, 32'(pipe_rst_n && !prev_pipe && !reg_rst_n), 32'd0);
    prev_reg  = reg_rst_n;
    prev_pipe = pipe_rst_n;
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end between a falling edge and the next rising edge.
  task automatic drive_cycle(input logic req_n);
    reg_cpu_rst_n = req_n;
    @(posedge clk);
    model_edge();
    #1;
    check_all("cyc");
    @(negedge clk);
  endtask

  task automatic hard_pulse(input string tag);
    #2;
    s_rst_n = 1'b0;
    #1;
    model_hard();
    check_all({tag, ".async"});
  endtask

  task automatic release_hard();
    #1;
    s_rst_n = 1'b1;
  endtask

  // Edge k counts from the first edge after s_rst_n release.
  task automatic release_check(input string tag);
    for (int k = 1; k <= REG + PIPE + SYNC + 3; k++) begin
      drive_cycle(1'b1);
      chk({tag, ".sync_at_edge"}, 32'(rst_sync_n), 32'(k >= 2));
      chk({tag, ".reg_at_edge"},  32'(reg_rst_n),  32'(k >= 6));
      chk({tag, ".pipe_at_edge"}, 32'(pipe_rst_n), 32'(k >= 22));
      chk({tag, ".done_at_edge"}, 32'(rst_done),   32'(k >= 22));
    end
  endtask

  // ---------------- stimulus ----------------
  int   act_cycles;
  int   r;
  logic cur_req;
  logic entered, exited;

  initial begin
    // Power-on
    s_rst_n       = 1'b0;
    reg_cpu_rst_n = 1'b1;
    model_hard();
    #1;
    check_all("por");
    @(negedge clk);
    repeat (5) drive_cycle(1'b1);
    release_hard();
    release_check("power_on");

    // Soft reset held for 20 sampled cycles; entry and exit both see the
    // same synchronizer delay, so SOFT_RST lasts 20 cycles.
    act_cycles = 0;
    for (int i = 0; i < 50; i++) begin
      drive_cycle(i < 20 ? 1'b0 : 1'b1);
      if (soft_rst_active) act_cycles++;
    end
    chk("soft20.active_cycles", act_cycles, 32'd20);
    chk("soft20.back_in_run", 32'(rst_done), 32'd1);

    // Short request is stretched to the minimum pulse
    act_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(i < 3 ? 1'b0 : 1'b1);
      if (soft_rst_active) act_cycles++;
    end
    chk("short.active_cycles", act_cycles, 32'(MIN));

    // Hard reset from RUN, then again in the middle of PIPE_WAIT
    hard_pulse("hard_run");
    repeat (2) drive_cycle(1'b1);
    release_hard();
    repeat (REG + 10) drive_cycle(1'b1);
    chk("mid_pipe.reg_released", 32'(reg_rst_n), 32'd1);
    chk("mid_pipe.pipe_held", 32'(pipe_rst_n), 32'd0);
    hard_pulse("hard_pipe_wait");
    chk("hard_pipe_wait.sync_low", 32'(rst_sync_n), 32'd0);
    chk("hard_pipe_wait.reg_low", 32'(reg_rst_n), 32'd0);
    repeat (3) drive_cycle(1'b1);
    release_hard();
    release_check("restart");

    // Soft request while the register block is still held
    hard_pulse("hard_pre_regwait");
    drive_cycle(1'b1);
    release_hard();
    entered = 1'b0;
    exited  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(i < 2 ? 1'b0 : 1'b1);
      if (soft_rst_active) entered = 1'b1;
      if (entered && !soft_rst_active) exited = 1'b1;
      chk("regwait_soft.reg_held", 32'(reg_rst_n && !exited), 32'd0);
    end
    chk("regwait_soft.entered", 32'(entered), 32'd1);

`ifdef RST_SEQ_CAUSE_EN
    // Soft-reset history across three soft resets and one hard reset
    hard_pulse("cause_hard");
    drive_cycle(1'b1);
    release_hard();
    repeat (30) drive_cycle(1'b1);
    for (int n = 0; n < 3; n++) begin
      repeat (2) drive_cycle(1'b0);
      repeat (30) drive_cycle(1'b1);
    end
    chk("cause.cnt_after3", 32'(soft_rst_cnt), 32'd3);
    chk("cause.last_after3", 32'(last_cause), 32'd1);
    hard_pulse("cause_clear");
    chk("cause.cnt_cleared", 32'(soft_rst_cnt), 32'd0);
    chk("cause.last_cleared", 32'(last_cause), 32'd0);
    drive_cycle(1'b1);
    release_hard();
`endif

    // Randomized soft request traffic with occasional hard resets
    cur_req = 1'b1;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        hard_pulse("rnd_hard");
        repeat ($urandom_range(1, 3)) drive_cycle(1'($urandom_range(0, 1)));
        release_hard();
      end else begin
        if (cur_req) begin
          if ($urandom_range(0, 19) == 0) cur_req = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          cur_req = 1'b1;
        end
        drive_cycle(cur_req);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
